// File: rtl/ahb_bus_matrix_pkg.sv
// Shared AHB bus-matrix definitions: HTRANS/HBURST encodings, output-port
// arbiter state type and the fixed-length burst beat lookup.
package ahb_bus_matrix_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'b000,
        HB_INCR   = 3'b001,
        HB_WRAP4  = 3'b010,
        HB_INCR4  = 3'b011,
        HB_WRAP8  = 3'b100,
        HB_INCR8  = 3'b101,
        HB_WRAP16 = 3'b110,
        HB_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        ST_NOPORT = 2'b00,
        ST_OWNED  = 2'b01,
        ST_BURST  = 2'b10,
        ST_LOCKED = 2'b11
    } arb_state_t;

    localparam int BEAT_CNT_W = 5;

    // Beats in a fixed-length burst; zero for SINGLE and undefined-length INCR.
    function automatic logic [BEAT_CNT_W-1:0] burst_beats(input hburst_t burst);
        case (burst)
            HB_WRAP4,  HB_INCR4:  burst_beats = 5'd4;
            HB_WRAP8,  HB_INCR8:  burst_beats = 5'd8;
            HB_WRAP16, HB_INCR16: burst_beats = 5'd16;
            default:              burst_beats = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_bus_matrix_rr_pick.sv
// Combinational round-robin selector: first requester strictly after
// i_last_grant, wrapping modulo NUM_IN.
module ahb_bus_matrix_rr_pick #(
    parameter int NUM_IN = 3
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [1:0]        i_last_grant,
    output logic [1:0]        o_index,
    output logic              o_valid
);

    logic       w_hi_found;
    logic       w_lo_found;
    logic       w_take_hi;
    logic       w_take_lo;
    logic [1:0] w_hi_idx;
    logic [1:0] w_lo_idx;

    // Lowest requester above last_grant wins; otherwise lowest at or below it.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_take_hi  = 1'b0;
        w_take_lo  = 1'b0;
        w_hi_idx   = 2'd0;
        w_lo_idx   = 2'd0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_take_hi  = i_req[i] & (2'(i) >  i_last_grant) & ~w_hi_found;
            w_take_lo  = i_req[i] & (2'(i) <= i_last_grant) & ~w_lo_found;
            w_hi_idx   = w_take_hi ? 2'(i) : w_hi_idx;
            w_lo_idx   = w_take_lo ? 2'(i) : w_lo_idx;
            w_hi_found = w_hi_found | w_take_hi;
            w_lo_found = w_lo_found | w_take_lo;
        end
        o_index = w_hi_found ? w_hi_idx : w_lo_idx;
        o_valid = w_hi_found | w_lo_found;
    end

endmodule

// File: rtl/ahb_bus_matrix_arbiter_rr.sv
// Round-robin arbiter for one AHB bus-matrix output port with lock and burst hold.
// Macro AHB_BM_ARB_BURST_HOLD_EN enables fixed-length burst hold (BURST state, beat counter).
module ahb_bus_matrix_arbiter_rr #(
    parameter int NUM_IN = 3
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [NUM_IN-1:0]     req_sel,
    input  logic [2*NUM_IN-1:0]   req_trans,
    input  logic [3*NUM_IN-1:0]   req_burst,
    input  logic [NUM_IN-1:0]     req_lock,
    input  logic                  HREADYM,
    output logic [1:0]            addr_in_port,
    output logic                  no_port,
    output logic [1:0]            data_in_port,
    output logic [NUM_IN-1:0]     active
);
    import ahb_bus_matrix_pkg::*;

    arb_state_t        r_state;
    arb_state_t        w_state_nx;
    logic [1:0]        r_addr_port;
    logic [1:0]        r_data_port;
    logic [1:0]        r_last_grant;
    logic              r_no_port;
    logic [NUM_IN-1:0] r_active;

    logic              w_own_sel;
    logic              w_own_lock;
    logic [1:0]        w_own_trans;
    logic              w_lock_req;
    logic              w_rearb;
    logic [1:0]        w_pick_idx;
    logic              w_pick_valid;
    logic [NUM_IN-1:0] w_pick_onehot;

`ifdef AHB_BM_ARB_BURST_HOLD_EN
    logic [2:0]            w_own_burst;
    logic [BEAT_CNT_W-1:0] w_beats;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [BEAT_CNT_W-1:0] w_beat_cnt_nx;
    assign w_beats = burst_beats(hburst_t'(w_own_burst));
`else
    logic w_unused_burst;
    assign w_unused_burst = ^req_burst;
`endif

    // Extract the current address-phase owner's request fields.
    always_comb begin
        w_own_sel   = 1'b0;
        w_own_lock  = 1'b0;
        w_own_trans = 2'b00;
`ifdef AHB_BM_ARB_BURST_HOLD_EN
        w_own_burst = 3'b000;
`endif
        for (int i = 0; i < NUM_IN; i++) begin
            w_own_sel   = w_own_sel   | ((r_addr_port == 2'(i)) & req_sel[i]);
            w_own_lock  = w_own_lock  | ((r_addr_port == 2'(i)) & req_lock[i]);
            w_own_trans = w_own_trans | ({2{r_addr_port == 2'(i)}} & req_trans[2*i +: 2]);
`ifdef AHB_BM_ARB_BURST_HOLD_EN
            w_own_burst = w_own_burst | ({3{r_addr_port == 2'(i)}} & req_burst[3*i +: 3]);
`endif
        end
    end

    assign w_lock_req = w_own_sel & w_own_lock & (w_own_trans != HT_IDLE);

    ahb_bus_matrix_rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_rr_pick (
        .i_req        (req_sel),
        .i_last_grant (r_last_grant),
        .o_index      (w_pick_idx),
        .o_valid      (w_pick_valid)
    );

    // One-hot form of the candidate grant for the active flags.
    always_comb begin
        w_pick_onehot = {NUM_IN{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            w_pick_onehot[i] = (w_pick_idx == 2'(i));
        end
    end

    // Hold/release decision per state; a release re-runs round-robin selection.
    always_comb begin
        w_rearb    = 1'b0;
        w_state_nx = r_state;
`ifdef AHB_BM_ARB_BURST_HOLD_EN
        w_beat_cnt_nx = r_beat_cnt;
`endif
        case (r_state)
            ST_NOPORT: w_rearb = 1'b1;
            ST_LOCKED: begin
                if ((w_own_trans == HT_IDLE) && !w_own_lock) begin
                    w_rearb = 1'b1;
                end else begin
                    w_rearb = 1'b0;
                end
            end
            ST_OWNED: begin
                if (w_lock_req) begin
                    w_state_nx = ST_LOCKED;
                end else if (!w_own_sel) begin
                    w_rearb = 1'b1;
`ifdef AHB_BM_ARB_BURST_HOLD_EN
                end else if ((w_own_trans == HT_NONSEQ) && (w_beats != 5'd0)) begin
                    w_state_nx    = ST_BURST;
                    w_beat_cnt_nx = w_beats - 5'd1;
`endif
                end else if ((w_own_trans == HT_SEQ) || (w_own_trans == HT_BUSY)) begin
                    w_rearb = 1'b0;
                end else begin
                    w_rearb = 1'b1;
                end
            end
`ifdef AHB_BM_ARB_BURST_HOLD_EN
            ST_BURST: begin
                // Lock takes priority; a dropped select aborts the burst early.
                if (w_lock_req) begin
                    w_state_nx    = ST_LOCKED;
                    w_beat_cnt_nx = 5'd0;
                end else if (!w_own_sel) begin
                    w_rearb = 1'b1;
                end else if (w_own_trans == HT_BUSY) begin
                    w_rearb = 1'b0;
                end else if (r_beat_cnt == 5'd0) begin
                    w_rearb = 1'b1;
                end else if (w_own_trans == HT_SEQ) begin
                    w_beat_cnt_nx = r_beat_cnt - 5'd1;
                end else begin
                    w_rearb = 1'b0;
                end
            end
`endif
            default: w_rearb = 1'b1;
        endcase
        if (w_rearb) begin
            w_state_nx = w_pick_valid ? ST_OWNED : ST_NOPORT;
`ifdef AHB_BM_ARB_BURST_HOLD_EN
            w_beat_cnt_nx = 5'd0;
`endif
        end else begin
            w_state_nx = w_state_nx;
        end
    end

    // Arbitration state and registered grant outputs, advanced only when HREADYM is high.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= ST_NOPORT;
            r_addr_port  <= 2'd0;
            r_data_port  <= 2'd0;
            r_no_port    <= 1'b1;
            r_active     <= {NUM_IN{1'b0}};
            r_last_grant <= 2'(NUM_IN - 1);
`ifdef AHB_BM_ARB_BURST_HOLD_EN
            r_beat_cnt   <= 5'd0;
`endif
        end else if (HREADYM) begin
            r_state <= w_state_nx;
`ifdef AHB_BM_ARB_BURST_HOLD_EN
            r_beat_cnt <= w_beat_cnt_nx;
`endif
            if (!r_no_port) begin
                r_data_port <= r_addr_port;
            end
            if (w_rearb && w_pick_valid) begin
                r_addr_port  <= w_pick_idx;
                r_last_grant <= w_pick_idx;
                r_no_port    <= 1'b0;
                r_active     <= w_pick_onehot;
            end else if (w_rearb) begin
                r_no_port <= 1'b1;
                r_active  <= {NUM_IN{1'b0}};
            end
        end
    end

    assign addr_in_port = r_addr_port;
    assign no_port      = r_no_port;
    assign data_in_port = r_data_port;
    assign active       = r_active;

endmodule
